// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Four-digit seven-segment scan sequencer with a 4-entry digit
//               register file, programmable dwell and inter-digit blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler #(
    parameter int DWELL_TICKS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_digit,
    input  logic [3:0] wr_value,
    input  logic       wr_blank,
    output logic [3:0] anode,
    output logic [1:0] digit_sel,
    output logic [3:0] digit_value,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] c_dwell_last = 8'(DWELL_TICKS - 1);
    localparam logic [7:0] c_blank_last = 8'(BLANK_TICKS - 1);
    // With no blanking the scan goes straight from one digit's drive to the next.
    localparam state_t     c_lead_state = (BLANK_TICKS == 0) ? ST_DRIVE : ST_BLANK;

    state_t          r_state_q, w_state_d;
    logic [7:0]      r_cnt_q, w_cnt_d;
    logic [1:0]      r_sel_q, w_sel_d;
    logic [3:0][3:0] r_value_q, w_value_d;
    logic [3:0]      r_blank_q, w_blank_d;
    logic [3:0]      r_anode_q, w_anode_d;
    logic [3:0]      r_dval_q, w_dval_d;
    logic            r_frame_q, w_frame_d;
    logic            w_wr_fire;

    // Writes to the digit currently lit are held off so it never tears.
    assign wr_ready  = ~reset & ~((r_state_q == ST_DRIVE) && (wr_digit == r_sel_q));
    assign w_wr_fire = wr_valid & wr_ready;

    always_comb begin
        w_value_d = r_value_q;
        w_blank_d = r_blank_q;
        if (w_wr_fire) begin
            w_value_d[wr_digit] = wr_value;
            w_blank_d[wr_digit] = wr_blank;
        end

        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_sel_d   = r_sel_q;
        w_frame_d = 1'b0;

        if (!enable) begin
            w_state_d = ST_OFF;
            w_cnt_d   = 8'd0;
            w_sel_d   = 2'd0;
        end else begin
            case (r_state_q)
                ST_OFF: begin
                    w_state_d = c_lead_state;
                    w_cnt_d   = 8'd0;
                    w_sel_d   = 2'd0;
                end
                ST_BLANK: begin
                    if (tick) begin
                        if (r_cnt_q == c_blank_last) begin
                            w_state_d = ST_DRIVE;
                            w_cnt_d   = 8'd0;
                        end else begin
                            w_cnt_d = r_cnt_q + 8'd1;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (tick) begin
                        if (r_cnt_q == c_dwell_last) begin
                            w_state_d = c_lead_state;
                            w_cnt_d   = 8'd0;
                            w_sel_d   = r_sel_q + 2'd1;
                            w_frame_d = (r_sel_q == 2'd3);
                        end else begin
                            w_cnt_d = r_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_OFF;
                    w_cnt_d   = 8'd0;
                    w_sel_d   = 2'd0;
                end
            endcase
        end

        // Outputs are registered from the post-edge view, including a same-edge write.
        w_anode_d = 4'hF;
        if ((w_state_d == ST_DRIVE) && !w_blank_d[w_sel_d]) begin
            w_anode_d = ~(4'b0001 << w_sel_d);
        end
        w_dval_d = (w_state_d == ST_OFF) ? 4'h0 : w_value_d[w_sel_d];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ST_OFF;
            r_cnt_q   <= 8'd0;
            r_sel_q   <= 2'd0;
            r_value_q <= '0;
            r_blank_q <= 4'hF;
            r_anode_q <= 4'hF;
            r_dval_q  <= 4'h0;
            r_frame_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_sel_q   <= w_sel_d;
            r_value_q <= w_value_d;
            r_blank_q <= w_blank_d;
            r_anode_q <= w_anode_d;
            r_dval_q  <= w_dval_d;
            r_frame_q <= w_frame_d;
        end
    end

    assign anode       = r_anode_q;
    assign digit_sel   = r_sel_q;
    assign digit_value = r_dval_q;
    assign frame_done  = r_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Self-checking bench for display_scheduler (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    localparam int C_D[2] = '{4, 1};
    localparam int C_B[2] = '{1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, tick, wv, wb;
    logic [1:0] wd;
    logic [3:0] wval;

    logic       a_rdy, a_fd, b_rdy, b_fd;
    logic [3:0] a_an, a_val, b_an, b_val;
    logic [1:0] a_sel, b_sel;

    display_scheduler #(.DWELL_TICKS(4), .BLANK_TICKS(1)) u_dut_a (
        .clock(clk), .reset(rst), .tick(tick), .enable(en),
        .wr_valid(wv), .wr_ready(a_rdy), .wr_digit(wd), .wr_value(wval), .wr_blank(wb),
        .anode(a_an), .digit_sel(a_sel), .digit_value(a_val), .frame_done(a_fd)
    );

    display_scheduler #(.DWELL_TICKS(1), .BLANK_TICKS(0)) u_dut_b (
        .clock(clk), .reset(rst), .tick(tick), .enable(en),
        .wr_valid(wv), .wr_ready(b_rdy), .wr_digit(wd), .wr_value(wval), .wr_blank(wb),
        .anode(b_an), .digit_sel(b_sel), .digit_value(b_val), .frame_done(b_fd)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference: position within a frame measured in ticks; each digit slot is
    // BLANK ticks dark followed by DWELL ticks lit.
    int         m_on[2];
    int         m_pos[2];
    logic [3:0] m_val[2][4];
    logic       m_blk[2][4];
    logic       m_fd[2];

    function automatic int m_slot(int i);
        return C_D[i] + C_B[i];
    endfunction
    function automatic int m_digit(int i);
        return m_pos[i] / m_slot(i);
    endfunction
    function automatic bit m_driving(int i);
        return (m_on[i] != 0) && ((m_pos[i] % m_slot(i)) >= C_B[i]);
    endfunction
    function automatic logic m_ready(int i);
        return !rst && !(m_driving(i) && (int'(wd) == m_digit(i)));
    endfunction
    function automatic logic [10:0] m_out(int i);
        logic [3:0] a;
        a = 4'hF;
        if (m_driving(i) && !m_blk[i][m_digit(i)]) a = ~(4'b0001 << m_digit(i));
        return {a, (m_on[i] != 0) ? 2'(m_digit(i)) : 2'b00,
                (m_on[i] != 0) ? m_val[i][m_digit(i)] : 4'h0, m_fd[i]};
    endfunction

    function automatic logic dut_rdy(int i);
        return (i == 0) ? a_rdy : b_rdy;
    endfunction
    function automatic logic [10:0] dut_out(int i);
        return (i == 0) ? {a_an, a_sel, a_val, a_fd} : {b_an, b_sel, b_val, b_fd};
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            logic r;
            r = m_ready(i);
            if (rst) begin
                m_on[i] = 0; m_pos[i] = 0; m_fd[i] = 1'b0;
                for (int e = 0; e < 4; e++) begin
                    m_val[i][e] = 4'h0; m_blk[i][e] = 1'b1;
                end
            end else begin
                if (wv && r) begin
                    m_val[i][wd] = wval; m_blk[i][wd] = wb;
                end
                m_fd[i] = 1'b0;
                if (!en) begin
                    m_on[i] = 0; m_pos[i] = 0;
                end else if (m_on[i] == 0) begin
                    m_on[i] = 1; m_pos[i] = 0;
                end else if (tick) begin
                    m_pos[i]++;
                    if (m_pos[i] == 4 * m_slot(i)) begin
                        m_pos[i] = 0; m_fd[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step_pre();
        #1;
        chk("ready_a_model", 16'(a_rdy), 16'(m_ready(0)));
        chk("ready_b_model", 16'(b_rdy), 16'(m_ready(1)));
    endtask

    task automatic step_post();
        @(posedge clk);
        model_update();
        #1;
        chk("outs_a_model", 16'(dut_out(0)), 16'(m_out(0)));
        chk("outs_b_model", 16'(dut_out(1)), 16'(m_out(1)));
        @(negedge clk);
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic drive(input logic r, input logic e, input logic t, input logic v,
                         input logic [1:0] d, input logic [3:0] x, input logic b);
        rst = r; en = e; tick = t; wv = v; wd = d; wval = x; wb = b;
    endtask

    typedef struct packed {
        logic       rst, en, tick, wv;
        logic [1:0] wd;
        logic [3:0] wval;
        logic       wb;
        logic       exp_rdy;
        logic [3:0] exp_an;
        logic [1:0] exp_sel;
        logic [3:0] exp_val;
        logic       exp_fd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int stall;
        int fd_cnt;
        bit acc;
        logic [3:0] acc_an;
        logic [1:0] acc_sel;

        for (int i = 0; i < 2; i++) begin
            m_on[i] = 0; m_pos[i] = 0; m_fd[i] = 1'b0;
            for (int e = 0; e < 4; e++) begin
                m_val[i][e] = 4'h0; m_blk[i][e] = 1'b1;
            end
        end

        // rst en tick wv wd wval wb | rdy anode sel val fd  (configuration A)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'h3, 1'b0, 1'b0, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h5, 1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'h6, 1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h7, 1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'h8, 1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 4'hF, 2'd0, 4'h5, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 4'hE, 2'd0, 4'h5, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'hE, 2'd0, 4'h5, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 1'b0, 4'hE, 2'd0, 4'h5, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'hC, 1'b0, 1'b1, 4'hE, 2'd0, 4'h5, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'hF, 2'd1, 4'hC, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b1, 4'hD, 2'd1, 4'hC, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 4'hF, 2'd0, 4'h0, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        @(negedge clk);

        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].rst, tbl[k].en, tbl[k].tick, tbl[k].wv, tbl[k].wd, tbl[k].wval, tbl[k].wb);
            step_pre();
            chk($sformatf("tbl%0d_ready", k), 16'(a_rdy), 16'(tbl[k].exp_rdy));
            step_post();
            chk($sformatf("tbl%0d_outs", k), 16'({a_an, a_sel, a_val, a_fd}),
                16'({tbl[k].exp_an, tbl[k].exp_sel, tbl[k].exp_val, tbl[k].exp_fd}));
        end

        // Stalled write to the digit being driven (configuration A, tick every cycle).
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        step();
        for (int e = 0; e < 4; e++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 2'(e), 4'(e + 1), 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        stall = 0;
        while (a_an !== 4'b1101 && stall < 40) begin
            step();
            stall++;
        end
        chk("reach_digit1_drive", 16'(a_an), 16'h000D);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h9, 1'b0);
        stall = 0;
        acc = 1'b0;
        acc_an = 4'h0;
        acc_sel = 2'd0;
        while (!acc && stall < 20) begin
            step_pre();
            acc = a_rdy;
            acc_an = a_an;
            acc_sel = a_sel;
            if (!acc) chk("stall_old_value", 16'(a_val), 16'h0002);
            step_post();
            if (!acc) stall++;
        end
        chk("stall_cycles", 16'(stall), 16'd4);
        chk("accept_in_blank", 16'({acc_an, acc_sel}), 16'({4'hF, 2'd2}));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        for (int k = 0; k < 12; k++) step();

        // Reset mid-frame clears the register file.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'h4, 1'b0);
        step_pre();
        chk("ready_in_reset", 16'(a_rdy), 16'h0000);
        step_post();
        chk("reset_outs", 16'({a_an, a_sel, a_val, a_fd}), 16'({4'hF, 2'd0, 4'h0, 1'b0}));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        step();
        step();
        chk("post_reset_dark", 16'({a_an, a_val}), 16'({4'hF, 4'h0}));

        // No blanking, one-tick dwell, tick every cycle (configuration B).
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        step();
        for (int e = 0; e < 4; e++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 2'(e), 4'(e + 10), 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
        fd_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] ea;
            ea = 4'b0001 << (k % 4);
            step();
            chk($sformatf("b_rotate%0d", k), 16'({b_an, b_fd}),
                16'({~ea, (k % 4 == 0) && (k > 0)}));
            if (b_fd === 1'b1) fd_cnt++;
        end
        chk("b_frame_count", 16'(fd_cnt), 16'd3);

        // Randomized traffic against the reference model.
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom % 250) == 0;
            if (($urandom % 60) == 0) en = ~en;
            tick = (k % 500 < 250) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            wv   = ($urandom % 2) == 0;
            wd   = 2'($urandom % 4);
            wval = 4'($urandom % 16);
            wb   = ($urandom % 5) == 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
